// File: rtl/mult_ctrl_pkg.sv
// Shared encodings and widths for the HI/LO multiply sequencing controller.
package mult_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int WORD_W  = 32;
    localparam int PROD_W  = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/mult_ctrl_watchdog.sv
// Cycle counter that flags expiry once it has been enabled for LIMIT cycles.
module mult_ctrl_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Holds its value while disabled so a flush into DRAIN keeps the WAIT budget running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Sequences MULT/MULTU through the iterative multiplier into HI/LO, stalling EX on hazards.
// Optional watchdog abort of WAIT/DRAIN is built only when MULT_CTRL_TIMEOUT_EN is defined.
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mult_req,
    input  logic              mult_signed,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [WORD_W-1:0] mt_data,
    input  logic              mfhi_req,
    input  logic              mflo_req,
    input  logic              flush,
    output logic [WORD_W-1:0] mul_a,
    output logic [WORD_W-1:0] mul_b,
    output logic              mul_start,
    output logic              mul_is_signed,
    input  logic [PROD_W-1:0] mul_s,
    input  logic              mul_ready,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              busy,
    output logic              stall,
    output logic              timeout_err
);

    state_e            r_state;
    state_e            w_next;
    logic              w_accept;
    logic              w_prod_we;
    logic              w_timeout;
    logic [WORD_W-1:0] r_mul_a;
    logic [WORD_W-1:0] r_mul_b;
    logic              r_mul_signed;
    logic [WORD_W-1:0] r_hi;
    logic [WORD_W-1:0] r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // GUARD exists because mul_ready may still show the previous idle/valid level right after start.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_prod_we = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mult_req) begin
                    w_next   = ST_START;
                    w_accept = 1'b1;
                end
            end
            ST_START: w_next = flush ? ST_DRAIN : ST_GUARD;
            ST_GUARD: w_next = flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (flush) begin
                    w_next = ST_DRAIN;
                end else if (mul_ready) begin
                    w_next    = ST_IDLE;
                    w_prod_we = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (mul_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_next    = ST_IDLE;
            w_prod_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_signed <= 1'b0;
        end else if (w_accept) begin
            r_mul_a      <= op_a;
            r_mul_b      <= op_b;
            r_mul_signed <= mult_signed;
        end
    end

    // MT writes only land in IDLE without a competing multiply; while busy they are held by stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_prod_we) begin
            r_hi <= mul_s[PROD_W-1:WORD_W];
            r_lo <= mul_s[WORD_W-1:0];
        end else if ((r_state == ST_IDLE) && !mult_req) begin
            if (mthi_we) begin
                r_hi <= mt_data;
            end
            if (mtlo_we) begin
                r_lo <= mt_data;
            end
        end
    end

`ifdef MULT_CTRL_TIMEOUT_EN
    logic w_wd_en;
    logic r_timeout_err;

    assign w_wd_en = (r_state == ST_WAIT) || (r_state == ST_DRAIN);

    mult_ctrl_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_en      (w_wd_en),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // Without the watchdog the limit is only a sanity gate on the tie-offs.
    if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
        assign w_timeout   = 1'b0;
        assign timeout_err = 1'b0;
    end
`endif

    assign mul_a         = r_mul_a;
    assign mul_b         = r_mul_b;
    assign mul_is_signed = r_mul_signed;
    assign mul_start     = (r_state == ST_START);
    assign hi            = r_hi;
    assign lo            = r_lo;
    assign busy          = (r_state != ST_IDLE);
    assign stall         = busy & (mult_req | mfhi_req | mflo_req | mthi_we | mtlo_we);

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboarded bench for mult_ctrl: expected HI/LO queued at issue, checked whenever busy drops.
module tb_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mult_req = 1'b0;
    logic        mult_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic        mfhi_req = 1'b0;
    logic        mflo_req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_start;
    logic        mul_is_signed;
    logic [63:0] mul_s = '0;
    logic        mul_ready = 1'b1;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        timeout_err;

    mult_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .mult_req      (mult_req),
        .mult_signed   (mult_signed),
        .op_a          (op_a),
        .op_b          (op_b),
        .mthi_we       (mthi_we),
        .mtlo_we       (mtlo_we),
        .mt_data       (mt_data),
        .mfhi_req      (mfhi_req),
        .mflo_req      (mflo_req),
        .flush         (flush),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_start     (mul_start),
        .mul_is_signed (mul_is_signed),
        .mul_s         (mul_s),
        .mul_ready     (mul_ready),
        .hi            (hi),
        .lo            (lo),
        .busy          (busy),
        .stall         (stall),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_start = 0;
    int   exp_starts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Multiplier stub: 4-cycle latency, ready drops after start; stub_hang freezes it.
    logic        stub_hang = 1'b0;
    int          stub_cnt = 0;
    logic [31:0] sa;
    logic [31:0] sb;
    logic        ss;

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_ready <= 1'b1;
            stub_cnt  <= 0;
        end else if (mul_start) begin
            mul_ready <= 1'b0;
            stub_cnt  <= 4;
            sa        <= mul_a;
            sb        <= mul_b;
            ss        <= mul_is_signed;
        end else if (stub_cnt > 0 && !stub_hang) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                mul_ready <= 1'b1;
                mul_s     <= prod(sa, sb, ss);
            end
        end
    end

    always @(negedge clk) begin
        if (mul_start) n_start++;
    end

    // Monitor: every busy->idle transition is one completed operation.
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_completion: hi=0x%0h lo=0x%0h, no entry queued", hi, lo);
            end else begin
                e = exp_q.pop_front();
                chk("completion_hilo", {hi, lo}, {e.hi, e.lo});
            end
        end
        prev_busy = busy;
    end

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk);
        #1;
        op_a        = a;
        op_b        = b;
        mult_signed = s;
        mult_req    = 1'b1;
        @(posedge clk);
        #1;
        mult_req = 1'b0;
        exp_starts++;
    endtask

    task automatic wait_idle(input string name, input int max, output int n,
                             output logic all_stall, output logic all_signed);
        n          = 0;
        all_stall  = 1'b1;
        all_signed = 1'b1;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (!busy) return;
            all_stall  = all_stall & stall;
            all_signed = all_signed & mul_is_signed;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: busy still 1 after %0d cycles, expected idle", name, max);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int   n;
        logic all_stall;
        logic all_signed;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_mul_ab", {mul_a, mul_b}, 64'h0);
        chk("reset_ctl", {59'b0, mul_start, mul_is_signed, busy, stall, timeout_err}, 64'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // MULTU 2003 x 99 = 198297
        exp_q.push_back('{hi: 32'h0000_0000, lo: 32'h0003_0699});
        do_mult(32'd2003, 32'd99, 1'b0);
        wait_idle("multu_small", 50, n, all_stall, all_signed);
        chk("multu_latency", 64'(n), 64'd7);
        chk("multu_one_start", 64'(n_start), 64'd1);

        // MULT -602 x 5 = -3010
        exp_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_F43E});
        do_mult(32'hFFFF_FDA6, 32'd5, 1'b1);
        wait_idle("mult_signed", 50, n, all_stall, all_signed);
        chk("signed_flag_held", 64'(all_signed), 64'd1);

        // MFHI hazard: 0x10000 * 0x10000 = 1 << 32
        exp_q.push_back('{hi: 32'h0000_0001, lo: 32'h0000_0000});
        do_mult(32'h0001_0000, 32'h0001_0000, 1'b0);
        mfhi_req = 1'b1;
        wait_idle("mfhi_hazard", 50, n, all_stall, all_signed);
        chk("mfhi_stall_while_busy", 64'(all_stall), 64'd1);
        chk("mfhi_after_ready", {31'b0, stall, hi}, {31'b0, 1'b0, 32'h0000_0001});
        @(posedge clk);
        #1 mfhi_req = 1'b0;

        // MTHI while busy is held off, then applied after completion
        exp_q.push_back('{hi: 32'h0, lo: 32'd42});
        do_mult(32'd7, 32'd6, 1'b0);
        mthi_we = 1'b1;
        mt_data = 32'hDEAD_BEEF;
        wait_idle("mthi_hazard", 50, n, all_stall, all_signed);
        chk("mthi_stall_while_busy", 64'(all_stall), 64'd1);
        @(posedge clk);
        #1 mthi_we = 1'b0;
        @(negedge clk);
        chk("mthi_applied", {hi, lo}, {32'hDEAD_BEEF, 32'd42});

        // Flush in WAIT: drain without writing, queued MULTU 9x9 stalls then runs
        stub_hang = 1'b1;
        exp_q.push_back('{hi: 32'hDEAD_BEEF, lo: 32'd42});
        exp_q.push_back('{hi: 32'h0, lo: 32'd81});
        do_mult(32'd5, 32'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        op_a     = 32'd9;
        op_b     = 32'd9;
        mult_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("drain_busy_stall", {62'b0, busy, stall}, 64'd3);
        chk("drain_hilo_kept", {hi, lo}, {32'hDEAD_BEEF, 32'd42});
        stub_hang = 1'b0;
        wait_idle("drain_exit", 50, n, all_stall, all_signed);
        @(posedge clk);
        #1 mult_req = 1'b0;
        exp_starts++;
        wait_idle("after_flush_mult", 50, n, all_stall, all_signed);

        // Reset in WAIT abandons the multiply
        stub_hang = 1'b1;
        exp_q.push_back('{hi: 32'h0, lo: 32'h0});
        do_mult(32'd100, 32'd100, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset_outputs",
            {mul_a[15:0], mul_b[15:0], hi[7:0], lo[7:0], 11'b0, mul_start, mul_is_signed, busy, stall, timeout_err},
            64'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        stub_hang = 1'b0;
        exp_q.push_back('{hi: 32'h0, lo: 32'd12});
        do_mult(32'd3, 32'd4, 1'b0);
        wait_idle("post_reset_mult", 50, n, all_stall, all_signed);
        chk("post_reset_hilo", {hi, lo}, {32'h0, 32'd12});

`ifdef MULT_CTRL_TIMEOUT_EN
        stub_hang = 1'b1;
        exp_q.push_back('{hi: 32'h0, lo: 32'd12});
        do_mult(32'd7, 32'd7, 1'b0);
        wait_idle("timeout_abort", 50, n, all_stall, all_signed);
        chk("timeout_cycles", 64'(n), 64'd11);
        chk("timeout_err_set", 64'(timeout_err), 64'd1);
`else
        chk("timeout_err_tied", 64'(timeout_err), 64'd0);
`endif

        repeat (2) @(negedge clk);
        chk("start_pulse_total", 64'(n_start), 64'(exp_starts));
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
